// File: rtl/tl_mem_responder_pkg.sv
// Shared TileLink opcode/param encodings, responder FSM states and beat arithmetic.
package tl_pkg;
    localparam logic [2:0] A_PUT_FULL      = 3'd0;
    localparam logic [2:0] A_PUT_PARTIAL   = 3'd1;
    localparam logic [2:0] A_GET           = 3'd4;
    localparam logic [2:0] A_ACQUIRE_BLOCK = 3'd6;
    localparam logic [2:0] A_ACQUIRE_PERM  = 3'd7;

    localparam logic [2:0] C_RELEASE       = 3'd6;
    localparam logic [2:0] C_RELEASE_DATA  = 3'd7;

    localparam logic [2:0] D_ACCESS_ACK      = 3'd0;
    localparam logic [2:0] D_ACCESS_ACK_DATA = 3'd1;
    localparam logic [2:0] D_GRANT           = 3'd4;
    localparam logic [2:0] D_GRANT_DATA      = 3'd5;
    localparam logic [2:0] D_RELEASE_ACK     = 3'd6;

    localparam logic [2:0] GROW_NTOB = 3'd0;
    localparam logic [2:0] GROW_NTOT = 3'd1;
    localparam logic [1:0] CAP_TOT   = 2'd0;
    localparam logic [1:0] CAP_TOB   = 2'd1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_A_DATA = 3'd1,
        S_C_DATA = 3'd2,
        S_D_RESP = 3'd3,
        S_WAIT_E = 3'd4
    } state_e;

    function automatic logic [4:0] beats_of(input logic [2:0] size);
        return (size <= 3'd3) ? 5'd1 : 5'(5'd1 << (size - 3'd3));
    endfunction
endpackage

// File: rtl/tl_mem_responder_if.sv
// TL-C channel bundle between the tile (master) and the memory responder (slave).
interface tl_mem_responder_if;
    logic        a_valid, a_ready;
    logic [2:0]  a_opcode, a_param, a_size, a_source;
    logic [31:0] a_address;
    logic [7:0]  a_mask;
    logic [63:0] a_data;

    logic        b_valid, b_ready;

    logic        c_valid, c_ready;
    logic [2:0]  c_opcode, c_param, c_size, c_source;
    logic [31:0] c_address;
    logic [63:0] c_data;

    logic        d_valid, d_ready;
    logic [2:0]  d_opcode;
    logic [1:0]  d_param;
    logic [2:0]  d_size, d_source;
    logic [1:0]  d_sink;
    logic [63:0] d_data;

    logic        e_valid, e_ready;
    logic [1:0]  e_sink;

    modport slave (
        input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data,
        output a_ready,
        output b_valid, input b_ready,
        input  c_valid, c_opcode, c_param, c_size, c_source, c_address, c_data,
        output c_ready,
        output d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_data,
        input  d_ready,
        input  e_valid, e_sink,
        output e_ready
    );

    modport master (
        output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data,
        input  a_ready,
        input  b_valid, output b_ready,
        output c_valid, c_opcode, c_param, c_size, c_source, c_address, c_data,
        input  c_ready,
        input  d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_data,
        output d_ready,
        output e_valid, e_sink,
        input  e_ready
    );
endinterface

// File: rtl/tl_mem_responder_mem_array.sv
// 64-bit word store: byte-enable write port, registered read port.
module tl_mem_array #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_mask,
    input  logic [63:0]   wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [63:0]   rd_data
);
    logic [63:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            for (int b = 0; b < 8; b++) begin
                if (wr_mask[b]) mem[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
            end
        end
    end

    // Only the read register is reset; array contents survive reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)     rd_data <= '0;
        else if (rd_en) rd_data <= mem[rd_addr];
    end
endmodule

// File: rtl/tl_mem_responder.sv
// TL-C manager backing a small word memory; one transaction in flight, never probes.
module tl_mem_responder
    import tl_pkg::*;
#(
    parameter int DEPTH    = 1024,
    parameter int MAX_SIZE = 6
) (
    input logic               clock,
    input logic               reset,
    tl_mem_responder_if.slave tl
);
    localparam int AW = $clog2(DEPTH);

    state_e        state;
    logic          alive;
    logic [2:0]    r_op, r_size, r_source;
    logic [1:0]    r_param, sink_ctr;
    logic [AW-1:0] base;
    logic [4:0]    k, nb;

    logic          a_fire, c_fire, d_fire, e_fire;
    logic          is_grant, has_data;
    logic          wr_en, rd_en;
    logic [AW-1:0] wr_addr, rd_addr;
    logic [7:0]    wr_mask;
    logic [63:0]   wr_data, rd_data;
    logic          unused_bits;

    // Oversized requests are clamped so the beat counter never exceeds one block.
    function automatic logic [4:0] beats_lim(input logic [2:0] size);
        return beats_of((int'(size) > MAX_SIZE) ? 3'(MAX_SIZE) : size);
    endfunction

    function automatic logic [AW-1:0] base_of(input logic [31:0] addr, input logic [2:0] size);
        return addr[AW+2:3] & ~AW'(beats_lim(size) - 5'd1);
    endfunction

    assign a_fire = tl.a_valid && tl.a_ready;
    assign c_fire = tl.c_valid && tl.c_ready;
    assign d_fire = tl.d_valid && tl.d_ready;
    assign e_fire = tl.e_valid && tl.e_ready;

    assign is_grant = (r_op == D_GRANT) || (r_op == D_GRANT_DATA);
    assign has_data = (r_op == D_ACCESS_ACK_DATA) || (r_op == D_GRANT_DATA);

    always_comb begin
        tl.a_ready = 1'b0;
        tl.c_ready = 1'b0;
        tl.e_ready = 1'b0;
        case (state)
            S_IDLE: begin
                tl.c_ready = alive;
                tl.a_ready = alive && !tl.c_valid;
            end
            S_A_DATA: tl.a_ready = alive;
            S_C_DATA: tl.c_ready = alive;
            S_WAIT_E: tl.e_ready = alive;
            default: ;
        endcase
    end

    // d_valid is a decode of the state register, so reset drops it at once.
    assign tl.b_valid  = 1'b0;
    assign tl.d_valid  = (state == S_D_RESP);
    assign tl.d_opcode = tl.d_valid ? r_op : 3'd0;
    assign tl.d_size   = tl.d_valid ? r_size : 3'd0;
    assign tl.d_source = tl.d_valid ? r_source : 3'd0;
    assign tl.d_param  = (tl.d_valid && is_grant) ? r_param : 2'd0;
    assign tl.d_sink   = (tl.d_valid && is_grant) ? sink_ctr : 2'd0;
    assign tl.d_data   = (tl.d_valid && has_data) ? rd_data : 64'd0;

    assign unused_bits = ^{tl.b_ready, tl.c_param, tl.a_address, tl.c_address};

    // First read is issued on the accepting edge so data is ready with d_valid.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = base + AW'(k);
        wr_mask = 8'hFF;
        wr_data = tl.c_data;
        rd_en   = 1'b0;
        rd_addr = base + AW'(k) + AW'(1);
        case (state)
            S_IDLE: begin
                if (c_fire) begin
                    wr_en   = (tl.c_opcode == C_RELEASE_DATA);
                    wr_addr = base_of(tl.c_address, tl.c_size);
                end else if (a_fire) begin
                    wr_en   = (tl.a_opcode == A_PUT_FULL) || (tl.a_opcode == A_PUT_PARTIAL);
                    wr_addr = base_of(tl.a_address, tl.a_size);
                    wr_mask = tl.a_mask;
                    wr_data = tl.a_data;
                    rd_en   = (tl.a_opcode == A_GET) || (tl.a_opcode == A_ACQUIRE_BLOCK);
                    rd_addr = base_of(tl.a_address, tl.a_size);
                end
            end
            S_A_DATA: begin
                wr_en   = a_fire;
                wr_mask = tl.a_mask;
                wr_data = tl.a_data;
            end
            S_C_DATA: wr_en = c_fire;
            S_D_RESP: rd_en = d_fire && (k != nb - 5'd1);
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            alive    <= 1'b0;
            sink_ctr <= 2'd0;
            r_op     <= 3'd0;
            r_size   <= 3'd0;
            r_source <= 3'd0;
            r_param  <= 2'd0;
            base     <= '0;
            k        <= 5'd0;
            nb       <= 5'd0;
        end else begin
            alive <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (c_fire) begin
                        r_size   <= tl.c_size;
                        r_source <= tl.c_source;
                        r_param  <= CAP_TOT;
                        r_op     <= D_RELEASE_ACK;
                        base     <= base_of(tl.c_address, tl.c_size);
                        if (tl.c_opcode == C_RELEASE_DATA && beats_lim(tl.c_size) > 5'd1) begin
                            state <= S_C_DATA;
                            nb    <= beats_lim(tl.c_size);
                            k     <= 5'd1;
                        end else begin
                            state <= S_D_RESP;
                            nb    <= 5'd1;
                            k     <= 5'd0;
                        end
                    end else if (a_fire) begin
                        r_size   <= tl.a_size;
                        r_source <= tl.a_source;
                        r_param  <= (tl.a_param == GROW_NTOB) ? CAP_TOB : CAP_TOT;
                        base     <= base_of(tl.a_address, tl.a_size);
                        state    <= S_D_RESP;
                        nb       <= 5'd1;
                        k        <= 5'd0;
                        case (tl.a_opcode)
                            A_GET: begin
                                r_op <= D_ACCESS_ACK_DATA;
                                nb   <= beats_lim(tl.a_size);
                            end
                            A_PUT_FULL, A_PUT_PARTIAL: begin
                                r_op <= D_ACCESS_ACK;
                                if (beats_lim(tl.a_size) > 5'd1) begin
                                    state <= S_A_DATA;
                                    nb    <= beats_lim(tl.a_size);
                                    k     <= 5'd1;
                                end
                            end
                            A_ACQUIRE_BLOCK: begin
                                r_op <= D_GRANT_DATA;
                                nb   <= beats_lim(tl.a_size);
                            end
                            A_ACQUIRE_PERM: r_op <= D_GRANT;
                            default:        r_op <= D_ACCESS_ACK;
                        endcase
                    end
                end
                S_A_DATA: begin
                    if (a_fire) begin
                        if (k == nb - 5'd1) begin
                            state <= S_D_RESP;
                            nb    <= 5'd1;
                            k     <= 5'd0;
                        end else begin
                            k <= k + 5'd1;
                        end
                    end
                end
                S_C_DATA: begin
                    if (c_fire) begin
                        if (k == nb - 5'd1) begin
                            state <= S_D_RESP;
                            nb    <= 5'd1;
                            k     <= 5'd0;
                        end else begin
                            k <= k + 5'd1;
                        end
                    end
                end
                S_D_RESP: begin
                    if (d_fire) begin
                        if (k == nb - 5'd1) state <= is_grant ? S_WAIT_E : S_IDLE;
                        else                k     <= k + 5'd1;
                    end
                end
                S_WAIT_E: begin
                    // A GrantAck for the wrong sink is swallowed; keep waiting for ours.
                    if (e_fire && tl.e_sink == sink_ctr) begin
                        sink_ctr <= sink_ctr + 2'd1;
                        state    <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    tl_mem_array #(.DEPTH(DEPTH), .AW(AW)) u_mem (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_mask (wr_mask),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );
endmodule

// File: tb/tb_tl_mem_responder.sv
// Directed bench: a word-level memory model plus an expected-D queue checked every valid cycle.
module tb_tl_mem_responder;
    import tl_pkg::*;

    localparam int DEPTH = 1024;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    tl_mem_responder_if tl();

    tl_mem_responder #(.DEPTH(DEPTH), .MAX_SIZE(6)) dut (
        .clock (clock),
        .reset (reset),
        .tl    (tl)
    );

    typedef struct {
        logic [2:0]  op;
        logic [1:0]  param;
        logic [2:0]  size;
        logic [2:0]  source;
        logic [1:0]  sink;
        logic [63:0] data;
    } dexp_t;

    logic [63:0] mm [int];
    dexp_t       exp_q [$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          msink    = 0;
    int          stalls   = 0;
    bit          stall_mode = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int nbeats(input int size);
        return (size <= 3) ? 1 : (1 << (size - 3));
    endfunction

    function automatic int widx(input int addr, input int size, input int k);
        int b;
        b = nbeats(size);
        return (((addr / 8) / b) * b + k) % DEPTH;
    endfunction

    function automatic void push(input int op, input int param, input int size,
                                 input int src, input int sink, input logic [63:0] data);
        dexp_t e;
        e.op = 3'(op); e.param = 2'(param); e.size = 3'(size);
        e.source = 3'(src); e.sink = 2'(sink); e.data = data;
        exp_q.push_back(e);
    endfunction

    // d_ready: held high, or alternating each cycle when stall_mode is set.
    initial begin
        tl.d_ready = 1'b1;
        forever begin
            @(posedge clock); #1;
            tl.d_ready = stall_mode ? ~tl.d_ready : 1'b1;
        end
    end

    // Compare process: every valid D beat must match the head of the expected queue.
    initial begin
        dexp_t e;
        forever begin
            @(negedge clock);
            if (reset && tl.d_valid) begin
                if (!tl.d_ready) stalls++;
                if (exp_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL d_unexpected: got opcode %0d with no response expected", tl.d_opcode);
                end else begin
                    e = exp_q[0];
                    chk("d_hdr", {tl.d_opcode, tl.d_param, tl.d_size, tl.d_source, tl.d_sink},
                                 {e.op, e.param, e.size, e.source, e.sink});
                    if (e.op == D_ACCESS_ACK_DATA || e.op == D_GRANT_DATA)
                        chk("d_data", tl.d_data, e.data);
                    if (tl.d_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic hs_a();
        bit ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clock);
            if (tl.a_ready) begin ok = 1'b1; break; end
        end
        @(posedge clock); #1;
        tl.a_valid = 1'b0;
        chk("a_handshake", ok, 1'b1);
    endtask

    task automatic a_beat(input logic [2:0] op, input logic [2:0] param, input logic [2:0] size,
                          input logic [2:0] src, input int addr, input logic [7:0] mask,
                          input logic [63:0] data);
        tl.a_valid = 1'b1; tl.a_opcode = op; tl.a_param = param; tl.a_size = size;
        tl.a_source = src; tl.a_address = 32'(addr); tl.a_mask = mask; tl.a_data = data;
        hs_a();
    endtask

    task automatic drain();
        for (int n = 0; n < 300; n++) begin
            @(posedge clock);
            if (exp_q.size() == 0) break;
        end
        #1;
        if (exp_q.size() != 0) begin
            chk("drain_timeout", 64'(exp_q.size()), 64'd0);
            exp_q.delete();
        end
    endtask

    task automatic do_put(input logic [2:0] op, input int size, input int addr,
                          input logic [7:0] mask, input logic [63:0] d0, input logic [63:0] step);
        logic [63:0] d, old;
        int w;
        for (int k = 0; k < nbeats(size); k++) begin
            w = widx(addr, size, k);
            d = d0 + step * 64'(k);
            old = mm.exists(w) ? mm[w] : 64'd0;
            for (int b = 0; b < 8; b++) if (mask[b]) old[b*8 +: 8] = d[b*8 +: 8];
            mm[w] = old;
        end
        push(D_ACCESS_ACK, 0, size, 1, 0, 64'd0);
        for (int k = 0; k < nbeats(size); k++)
            a_beat(op, 3'd0, 3'(size), 3'd1, addr, mask, d0 + step * 64'(k));
        drain();
    endtask

    task automatic do_get(input int size, input int src, input int addr);
        for (int k = 0; k < nbeats(size); k++)
            push(D_ACCESS_ACK_DATA, 0, size, src, 0, mm[widx(addr, size, k)]);
        a_beat(A_GET, 3'd0, 3'(size), 3'(src), addr, 8'hFF, 64'd0);
        chk("get_latency_dvalid", tl.d_valid, 1'b1);
    endtask

    task automatic acquire(input logic [2:0] op, input int param, input int size,
                           input int src, input int addr);
        int cap;
        cap = (param == 0) ? 1 : 0;
        if (op == A_ACQUIRE_BLOCK)
            for (int k = 0; k < nbeats(size); k++)
                push(D_GRANT_DATA, cap, size, src, msink, mm[widx(addr, size, k)]);
        else
            push(D_GRANT, cap, size, src, msink, 64'd0);
        a_beat(op, 3'(param), 3'(size), 3'(src), addr, 8'hFF, 64'd0);
    endtask

    task automatic send_e(input int sink);
        bit ok = 1'b0;
        tl.e_valid = 1'b1; tl.e_sink = 2'(sink);
        for (int n = 0; n < 200; n++) begin
            @(negedge clock);
            if (tl.e_ready) begin ok = 1'b1; break; end
        end
        @(posedge clock); #1;
        tl.e_valid = 1'b0;
        chk("e_handshake", ok, 1'b1);
        if (sink == msink) msink = (msink + 1) % 4;
    endtask

    initial begin
        tl.a_valid = 0; tl.a_opcode = 0; tl.a_param = 0; tl.a_size = 0; tl.a_source = 0;
        tl.a_address = 0; tl.a_mask = 0; tl.a_data = 0; tl.b_ready = 0;
        tl.c_valid = 0; tl.c_opcode = 0; tl.c_param = 0; tl.c_size = 0; tl.c_source = 0;
        tl.c_address = 0; tl.c_data = 0; tl.e_valid = 0; tl.e_sink = 0;

        // Reset state
        repeat (3) @(posedge clock); #1;
        chk("rst_valids", {tl.d_valid, tl.b_valid}, 2'b00);
        chk("rst_readies", {tl.a_ready, tl.c_ready, tl.e_ready}, 3'b000);
        chk("rst_d_fields", {tl.d_opcode, tl.d_param, tl.d_size, tl.d_source, tl.d_sink, tl.d_data}, 0);
        @(negedge clock); reset = 1'b1; #1;
        chk("alive_gate", {tl.a_ready, tl.c_ready}, 2'b00);
        @(posedge clock); #1;
        chk("alive_up", {tl.a_ready, tl.c_ready}, 2'b11);

        // PutFull then Get
        do_put(A_PUT_FULL, 3, 'h40, 8'hFF, 64'hDEADBEEF_01234567, 64'd0);
        do_get(3, 5, 'h40);
        chk("get_literal", {tl.d_source, tl.d_data}, {3'd5, 64'hDEADBEEF_01234567});
        drain();

        // PutPartial over zeros, plus an aliased address one array-length higher
        do_put(A_PUT_FULL, 3, 'h40, 8'hFF, 64'd0, 64'd0);
        do_put(A_PUT_PARTIAL, 3, 'h40, 8'h0F, 64'hFFFFFFFF_AAAAAAAA, 64'd0);
        chk("model_partial", mm[8], 64'h00000000_AAAAAAAA);
        do_get(3, 1, 'h40);
        chk("partial_literal", tl.d_data, 64'h00000000_AAAAAAAA);
        drain();
        do_get(3, 2, 'h40 + DEPTH * 8);
        chk("alias_literal", tl.d_data, 64'h00000000_AAAAAAAA);
        drain();

        // AcquireBlock with stalls, GrantAck sink matching
        do_put(A_PUT_FULL, 6, 'h100, 8'hFF, 64'h11110000_00000000, 64'd1);
        stall_mode = 1'b1;
        acquire(A_ACQUIRE_BLOCK, GROW_NTOT, 6, 3, 'h100);
        drain();
        stall_mode = 1'b0;
        chk("stall_seen", stalls > 0, 1'b1);
        chk("wait_e_ready", {tl.e_ready, tl.a_ready}, 2'b10);
        send_e(1);
        chk("e_mismatch_stays", {tl.e_ready, tl.a_ready}, 2'b10);
        send_e(0);
        chk("e_match_idle", {tl.e_ready, tl.a_ready}, 2'b01);
        chk("model_sink", msink, 1);
        acquire(A_ACQUIRE_PERM, GROW_NTOB, 6, 4, 'h100);
        chk("grant_literal", {tl.d_opcode, tl.d_param, tl.d_sink}, {D_GRANT, 2'd1, 2'd1});
        drain();
        send_e(1);

        // C and A together: ReleaseData wins, Get waits and then reads the released data
        mm[widx('h200, 4, 0)] = 64'hC0C0_0000_0000_0001;
        mm[widx('h200, 4, 1)] = 64'hC0C0_0000_0000_0002;
        push(D_RELEASE_ACK, 0, 4, 2, 0, 64'd0);
        push(D_ACCESS_ACK_DATA, 0, 4, 6, 0, mm[widx('h200, 4, 0)]);
        push(D_ACCESS_ACK_DATA, 0, 4, 6, 0, mm[widx('h200, 4, 1)]);
        tl.c_valid = 1; tl.c_opcode = C_RELEASE_DATA; tl.c_size = 4; tl.c_source = 2;
        tl.c_address = 32'h200; tl.c_data = 64'hC0C0_0000_0000_0001;
        tl.a_valid = 1; tl.a_opcode = A_GET; tl.a_param = 0; tl.a_size = 4; tl.a_source = 6;
        tl.a_address = 32'h200; tl.a_mask = 8'hFF;
        @(negedge clock);
        chk("prio_c_over_a", {tl.c_ready, tl.a_ready}, 2'b10);
        @(posedge clock); #1;
        tl.c_data = 64'hC0C0_0000_0000_0002;
        @(negedge clock);
        chk("cdata_a_blocked", {tl.c_ready, tl.a_ready}, 2'b10);
        @(posedge clock); #1;
        tl.c_valid = 1'b0;
        hs_a();
        drain();

        // Size-6 Get near the top of the array aligns down to DEPTH-8
        do_put(A_PUT_FULL, 6, (DEPTH - 8) * 8, 8'hFF, 64'hA5A50000_00000000, 64'd3);
        chk("model_wrap_base", widx((DEPTH - 2) * 8, 6, 0), DEPTH - 8);
        do_get(6, 7, (DEPTH - 2) * 8);
        chk("wrap_literal", tl.d_data, 64'hA5A50000_00000000);
        drain();

        // Reset during the third GrantData beat
        acquire(A_ACQUIRE_BLOCK, GROW_NTOT, 6, 0, 'h100);
        @(posedge clock); @(posedge clock); #2;
        reset = 1'b0; #1;
        chk("rst_async_dvalid", tl.d_valid, 1'b0);
        exp_q.delete();
        msink = 0;
        @(negedge clock); reset = 1'b1; #1;
        chk("post_rst_gate", {tl.a_ready, tl.c_ready, tl.e_ready}, 3'b000);
        @(posedge clock); #1;
        chk("post_rst_alive", {tl.a_ready, tl.c_ready}, 2'b11);
        do_get(6, 0, 'h100);
        chk("mem_kept_literal", tl.d_data, 64'h11110000_00000000);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
